// File: rtl/fht_result_reader_if.sv
// Stream and result-RAM signal bundle for fht_result_reader.
// The slave modport is the reader; the master modport is the RAM/sink/control side.
interface fht_result_reader_if #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
);
  logic                    iSTART;
  logic                    iFHT_RDY;
  logic [A_BIT-1:0]        oADDR_RD_0;
  logic [A_BIT-1:0]        oADDR_RD_1;
  logic [A_BIT-1:0]        oADDR_RD_2;
  logic [A_BIT-1:0]        oADDR_RD_3;
  logic signed [D_BIT-1:0] iDATA_0;
  logic signed [D_BIT-1:0] iDATA_1;
  logic signed [D_BIT-1:0] iDATA_2;
  logic signed [D_BIT-1:0] iDATA_3;
  logic signed [D_BIT-1:0] oDATA;
  logic [A_BIT+1:0]        oIDX;
  logic                    oVALID;
  logic                    iREADY;
  logic                    oLAST;
  logic                    oBUSY;
  logic                    oDONE;
  logic                    oERR;

  modport slave (
    input  iSTART, iFHT_RDY, iDATA_0, iDATA_1, iDATA_2, iDATA_3, iREADY,
    output oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
    output oDATA, oIDX, oVALID, oLAST, oBUSY, oDONE, oERR
  );

  modport master (
    output iSTART, iFHT_RDY, iDATA_0, iDATA_1, iDATA_2, iDATA_3, iREADY,
    input  oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
    input  oDATA, oIDX, oVALID, oLAST, oBUSY, oDONE, oERR
  );
endinterface

// File: rtl/fht_result_reader.sv
// Unloads the four-bank FHT result RAM as an in-order valid/ready stream,
// using read credits so a small skid FIFO absorbs every in-flight RAM word.
module fht_result_reader #(
  parameter int N          = 1024,
  parameter int A_BIT      = 8,
  parameter int D_BIT      = 16,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic               iCLK,
  input logic               iRESET,
  fht_result_reader_if.slave bus
);
  localparam int K_W   = A_BIT + 2;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IF_W  = $clog2(RD_LAT + 2);
  localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

  state_t                          state_q, state_d;
  logic [K_W-1:0]                  rc_q, rc_d, oc_q, oc_d;
  logic [A_BIT-1:0]                addr_q, addr_d;
  logic [RD_LAT:0]                 vld_q, vld_d;
  logic [RD_LAT:0][1:0]            tag_q, tag_d;
  logic [FIFO_DEPTH-1:0][D_BIT-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]                wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            done_q, done_d, err_q, err_d;

  logic [IF_W-1:0]                 in_flight_s;
  logic [D_BIT-1:0]                land_data_s;
  logic                            valid_s, xfer_s, land_s, last_s, credit_s, abort_s;

  // Loader stores banks in bit-reversed order of the two index MSBs.
  function automatic logic [1:0] bank_of(input logic [K_W-1:0] k);
    return {k[A_BIT], k[A_BIT+1]};
  endfunction

  assign valid_s = (cnt_q != '0);
  assign xfer_s  = valid_s & bus.iREADY;
  assign land_s  = vld_q[RD_LAT];
  assign last_s  = valid_s & (oc_q == K_LAST);
  assign abort_s = (state_q != IDLE) & ~bus.iFHT_RDY;

  always_comb begin
    in_flight_s = '0;
    for (int i = 0; i <= RD_LAT; i++) begin
      in_flight_s = in_flight_s + IF_W'(vld_q[i]);
    end
  end

  // A slot popped this clock is free again by the time a new read lands.
  assign credit_s = (int'(cnt_q) - int'(xfer_s) + int'(in_flight_s)) < FIFO_DEPTH;

  always_comb begin
    case (tag_q[RD_LAT])
      2'd0:    land_data_s = bus.iDATA_0;
      2'd1:    land_data_s = bus.iDATA_1;
      2'd2:    land_data_s = bus.iDATA_2;
      2'd3:    land_data_s = bus.iDATA_3;
      default: land_data_s = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    oc_d    = oc_q;
    addr_d  = addr_q;
    vld_d   = {vld_q[RD_LAT-1:0], 1'b0};
    tag_d   = {tag_q[RD_LAT-1:0], 2'b00};
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (land_s) begin
      mem_d[wr_q] = land_data_s;
      wr_d        = wr_q + PTR_W'(1);
    end else begin
      wr_d = wr_q;
    end
    if (xfer_s) begin
      rd_d = rd_q + PTR_W'(1);
      oc_d = oc_q + K_W'(1);
    end else begin
      rd_d = rd_q;
    end
    cnt_d = cnt_q + CNT_W'(land_s) - CNT_W'(xfer_s);

    case (state_q)
      IDLE: begin
        if (bus.iSTART && bus.iFHT_RDY) begin
          addr_d   = '0;
          vld_d[0] = 1'b1;
          tag_d[0] = 2'b00;
          rc_d     = K_W'(1);
          oc_d     = '0;
          state_d  = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (credit_s) begin
          addr_d   = rc_q[A_BIT-1:0];
          vld_d[0] = 1'b1;
          tag_d[0] = bank_of(rc_q);
          rc_d     = rc_q + K_W'(1);
          state_d  = (rc_q == K_LAST) ? DRAIN : READ;
        end else begin
          state_d = READ;
        end
      end
      DRAIN: begin
        if (xfer_s && last_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
          rc_d    = '0;
          oc_d    = '0;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase

    // Losing the transform result mid-unload discards everything queued or in flight.
    if (abort_s) begin
      state_d = IDLE;
      err_d   = 1'b1;
      done_d  = 1'b0;
      vld_d   = '0;
      cnt_d   = '0;
      wr_d    = '0;
      rd_d    = '0;
      rc_d    = '0;
      oc_d    = '0;
    end else begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q <= IDLE;
      rc_q    <= '0;
      oc_q    <= '0;
      addr_q  <= '0;
      vld_q   <= '0;
      tag_q   <= '0;
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      oc_q    <= oc_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      tag_q   <= tag_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.oADDR_RD_0 = addr_q;
  assign bus.oADDR_RD_1 = addr_q;
  assign bus.oADDR_RD_2 = addr_q;
  assign bus.oADDR_RD_3 = addr_q;
  assign bus.oDATA      = valid_s ? mem_q[rd_q] : '0;
  assign bus.oIDX       = oc_q;
  assign bus.oVALID     = valid_s;
  assign bus.oLAST      = last_s;
  assign bus.oBUSY      = (state_q != IDLE);
  assign bus.oDONE      = done_q;
  assign bus.oERR       = err_q;
endmodule

// File: tb/tb_fht_result_reader.sv
// Self-checking bench for fht_result_reader: scenario table of full unloads
// plus hand-written sequences for refused start, back-pressure and reset.
module tb_fht_result_reader;
  localparam int N = 1024, A_BIT = 8, D_BIT = 16, RD_LAT = 2, FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fht_result_reader_if #(.A_BIT(A_BIT), .D_BIT(D_BIT)) bus ();

  fht_result_reader #(
    .N(N), .A_BIT(A_BIT), .D_BIT(D_BIT), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .iCLK  (clk),
    .iRESET(rst_n),
    .bus   (bus)
  );

  // Four-bank RAM, bank b address a holds b*256+a, two-register read path.
  logic [D_BIT-1:0] st1 [4];
  logic [D_BIT-1:0] st2 [4];

  function automatic logic [D_BIT-1:0] ram_word(input int b, input int a);
    return D_BIT'(b * 256 + a);
  endfunction

  function automatic logic [D_BIT-1:0] exp_word(input int k);
    logic [9:0] kk;
    kk = k[9:0];
    return ram_word(int'({kk[8], kk[9]}), int'(kk[7:0]));
  endfunction

  always @(posedge clk) begin
    st1[0] <= ram_word(0, int'(bus.oADDR_RD_0));
    st1[1] <= ram_word(1, int'(bus.oADDR_RD_1));
    st1[2] <= ram_word(2, int'(bus.oADDR_RD_2));
    st1[3] <= ram_word(3, int'(bus.oADDR_RD_3));
    for (int b = 0; b < 4; b++) st2[b] <= st1[b];
  end

  assign bus.iDATA_0 = st2[0];
  assign bus.iDATA_1 = st2[1];
  assign bus.iDATA_2 = st2[2];
  assign bus.iDATA_3 = st2[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int pct;
    int abort_after;
    bit chk_lat;
    int exp_words;
    int exp_done;
    int exp_err;
  } scen_t;

  scen_t tbl [5];

  task automatic run_unload(input int pct, input int abort_after, input bit chk_lat,
                            output int words, output int dones, output int errs);
    int exp_k = 0, c = 0, first = -1, last_c = -1, done_c = -1, err_c = -1, abort_c = -1;
    bit stalled = 1'b0, fin = 1'b0;
    logic [D_BIT-1:0] hold_d = '0;
    logic [A_BIT+1:0] hold_i = '0;
    words = 0; dones = 0; errs = 0;
    bus.iSTART = 1'b1;
    tick();
    bus.iSTART = 1'b0;
    while (!fin && c < 20000) begin
      if (bus.oDONE) begin dones++; done_c = c; end
      if (bus.oERR)  begin errs++;  err_c  = c; end
      if (bus.oVALID && first < 0) first = c;
      if (stalled && abort_c < 0) begin
        check("stall_valid", 32'(bus.oVALID), 32'd1);
        check("stall_data", 32'(bus.oDATA), 32'(hold_d));
        check("stall_idx", 32'(bus.oIDX), 32'(hold_i));
      end
      if (done_c >= 0 || err_c >= 0) begin
        check("busy_end", 32'(bus.oBUSY), 32'd0);
        check("valid_end", 32'(bus.oVALID), 32'd0);
        fin = 1'b1;
      end else begin
        check("busy_run", 32'(bus.oBUSY), 32'd1);
        if (abort_after > 0 && words == abort_after && abort_c < 0) begin
          abort_c = c;
          bus.iFHT_RDY = 1'b0;
          bus.iREADY = 1'b0;
        end else begin
          bus.iREADY = ($urandom_range(0, 99) < pct);
        end
        if (bus.oVALID && bus.iREADY) begin
          check("word_idx", 32'(bus.oIDX), 32'(exp_k));
          check("word_data", 32'(bus.oDATA), 32'(exp_word(exp_k)));
          check("word_last", 32'(bus.oLAST), 32'(exp_k == N - 1));
          if (bus.oLAST) last_c = c;
          exp_k++;
          words++;
        end
        stalled = bus.oVALID && !bus.iREADY;
        hold_d = bus.oDATA;
        hold_i = bus.oIDX;
        tick();
        c++;
      end
    end
    check("unload_timeout", 32'(fin), 32'd1);
    bus.iFHT_RDY = 1'b1;
    bus.iREADY = 1'b1;
    if (chk_lat) begin
      check("first_valid_latency", 32'(first), 32'(RD_LAT + 1));
      check("full_rate_last_cycle", 32'(last_c), 32'(RD_LAT + N));
    end
    if (last_c >= 0) check("done_after_last", 32'(done_c), 32'(last_c + 1));
    if (abort_c >= 0) check("err_after_drop", 32'(err_c), 32'(abort_c + 1));
  endtask

  initial begin
    int w, d, e;
    tbl[0] = '{pct: 100, abort_after: 0,   chk_lat: 1'b1, exp_words: N,   exp_done: 1, exp_err: 0};
    tbl[1] = '{pct: 30,  abort_after: 0,   chk_lat: 1'b0, exp_words: N,   exp_done: 1, exp_err: 0};
    tbl[2] = '{pct: 100, abort_after: 100, chk_lat: 1'b0, exp_words: 100, exp_done: 0, exp_err: 1};
    tbl[3] = '{pct: 100, abort_after: 0,   chk_lat: 1'b1, exp_words: N,   exp_done: 1, exp_err: 0};
    tbl[4] = '{pct: 70,  abort_after: 0,   chk_lat: 1'b0, exp_words: N,   exp_done: 1, exp_err: 0};

    rst_n = 1'b0;
    bus.iSTART = 1'b0;
    bus.iFHT_RDY = 1'b1;
    bus.iREADY = 1'b1;
    #1;
    check("rst_valid", 32'(bus.oVALID), 32'd0);
    check("rst_busy", 32'(bus.oBUSY), 32'd0);
    check("rst_done", 32'(bus.oDONE), 32'd0);
    check("rst_err", 32'(bus.oERR), 32'd0);
    check("rst_last", 32'(bus.oLAST), 32'd0);
    check("rst_addr", 32'({bus.oADDR_RD_0, bus.oADDR_RD_3}), 32'd0);
    check("rst_data", 32'(bus.oDATA), 32'd0);
    check("rst_idx", 32'(bus.oIDX), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int s = 0; s < 5; s++) begin
      run_unload(tbl[s].pct, tbl[s].abort_after, tbl[s].chk_lat, w, d, e);
      check($sformatf("scen%0d_words", s), 32'(w), 32'(tbl[s].exp_words));
      check($sformatf("scen%0d_done", s), 32'(d), 32'(tbl[s].exp_done));
      check($sformatf("scen%0d_err", s), 32'(e), 32'(tbl[s].exp_err));
      repeat (3) tick();
    end

    // Start request while the transform is not ready is ignored.
    bus.iFHT_RDY = 1'b0;
    bus.iSTART = 1'b1;
    tick();
    bus.iSTART = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("nordy_busy", 32'(bus.oBUSY), 32'd0);
      check("nordy_done", 32'(bus.oDONE), 32'd0);
      check("nordy_valid", 32'(bus.oVALID), 32'd0);
      tick();
    end
    bus.iFHT_RDY = 1'b1;

    // Sink stalled from the start: only FIFO_DEPTH reads may be issued.
    bus.iREADY = 1'b0;
    bus.iSTART = 1'b1;
    tick();
    bus.iSTART = 1'b0;
    repeat (50) tick();
    check("stall_reads_addr0", 32'(bus.oADDR_RD_0), 32'(FIFO_DEPTH - 1));
    check("stall_reads_addr3", 32'(bus.oADDR_RD_3), 32'(FIFO_DEPTH - 1));
    check("stall_hold_valid", 32'(bus.oVALID), 32'd1);
    check("stall_hold_idx", 32'(bus.oIDX), 32'd0);
    check("stall_hold_busy", 32'(bus.oBUSY), 32'd1);

    // Asynchronous reset in the middle of the unload.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.oVALID), 32'd0);
    check("arst_busy", 32'(bus.oBUSY), 32'd0);
    check("arst_addr", 32'(bus.oADDR_RD_0), 32'd0);
    check("arst_idx", 32'(bus.oIDX), 32'd0);
    check("arst_data", 32'(bus.oDATA), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.iREADY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("arst_no_done", 32'(bus.oDONE), 32'd0);
      check("arst_no_err", 32'(bus.oERR), 32'd0);
    end
    run_unload(100, 0, 1'b1, w, d, e);
    check("post_rst_words", 32'(w), 32'(N));
    check("post_rst_done", 32'(d), 32'd1);
    check("post_rst_err", 32'(e), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
